// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg
// Shared constants, state encoding and pixel-address helper for the
// VGA rectangle-fill master.
// Revision: 1.0
// ============================================================================
package vga_pkg;

  localparam int VGA_H_PIXELS = 640;
  localparam int VGA_V_PIXELS = 480;

  // Word address of the frame-buffer swap register
  localparam logic [19:0] SWAP_ADDR = 20'h80000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_FILL   = 3'd2,
    S_VERIFY = 3'd3,
    S_SWAP   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // Pixel word address: bit 19 clear selects the pixel space
  function automatic logic [19:0] pixel_addr(input logic [8:0] y, input logic [9:0] x);
    return {1'b0, y, x};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_raster_walker.sv
`default_nettype none
// ============================================================================
// vga_raster_walker
// Raster-order x/y position counter over a rectangle, with look-ahead
// next position and last-pixel flag.
// Revision: 1.0
// ============================================================================
module vga_raster_walker (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [9:0] x0_i,
  input  logic [8:0] y0_i,
  input  logic [9:0] width_i,
  input  logic [8:0] height_i,
  input  logic       advance_i,
  output logic [9:0] x_o,
  output logic [8:0] y_o,
  output logic [9:0] nxt_x_o,
  output logic [8:0] nxt_y_o,
  output logic       last_o
);

  logic [9:0] x_q, x0_q, xend_q;
  logic [8:0] y_q, yend_q;
  logic       last_col;

  assign last_col = (x_q == xend_q);
  assign last_o   = last_col && (y_q == yend_q);
  assign nxt_x_o  = last_col ? x0_q : x_q + 10'd1;
  assign nxt_y_o  = last_col ? y_q + 9'd1 : y_q;
  assign x_o      = x_q;
  assign y_o      = y_q;

  // Load the rectangle corners, then step one pixel per advance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q    <= '0;
      y_q    <= '0;
      x0_q   <= '0;
      xend_q <= '0;
      yend_q <= '0;
    end else if (load_i) begin
      x_q    <= x0_i;
      y_q    <= y0_i;
      x0_q   <= x0_i;
      xend_q <= x0_i + width_i - 10'd1;
      yend_q <= y0_i + height_i - 9'd1;
    end else if (advance_i) begin
      x_q <= nxt_x_o;
      y_q <= nxt_y_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/avalon_vga_rect_fill_master.sv
`default_nettype none
// ============================================================================
// avalon_vga_rect_fill_master
// Avalon-MM master that fills a rectangle of the 3-bit VGA frame buffer,
// optionally reads it back to count mismatches, and optionally swaps buffers.
// Revision: 1.0
// ============================================================================
module avalon_vga_rect_fill_master
  import vga_pkg::*;
#(
  parameter int H_PIXELS    = VGA_H_PIXELS,
  parameter int V_PIXELS    = VGA_V_PIXELS,
  parameter int MAX_PENDING = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [9:0]  i_x0,
  input  logic [8:0]  i_y0,
  input  logic [9:0]  i_width,
  input  logic [8:0]  i_height,
  input  logic [2:0]  i_color,
  input  logic        i_verify,
  input  logic        i_swap,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_mismatch_cnt,
  output logic [19:0] o_address,
  output logic        o_write,
  output logic        o_read,
  output logic [31:0] o_writedata,
  input  logic [31:0] i_readdata,
  input  logic        i_readdatavalid,
  input  logic        i_waitrequest
);

  localparam int PW = $clog2(MAX_PENDING + 1);

  state_e      state_q;
  logic [9:0]  x0_q, width_q;
  logic [8:0]  y0_q, height_q;
  logic [2:0]  color_q;
  logic        verify_q, swap_q, issued_all_q;
  logic        busy_q, done_q, error_q, write_q, read_q;
  logic [19:0] address_q;
  logic [31:0] writedata_q;
  logic [15:0] mismatch_q;
  logic [PW-1:0] pending_q, pending_d;

  logic [9:0]  iss_x, iss_nxt_x, rsp_x, rsp_nxt_x;
  logic [8:0]  iss_y, iss_nxt_y, rsp_y, rsp_nxt_y;
  logic        iss_last, rsp_last;
  logic        iss_load, iss_adv, rsp_load;
  logic        wr_acc, rd_acc, rsp_fire;
  logic [10:0] x_end;
  logic [9:0]  y_end;

  assign wr_acc   = write_q && !i_waitrequest;
  assign rd_acc   = read_q && !i_waitrequest;
  assign rsp_fire = (state_q == S_VERIFY) && i_readdatavalid && (pending_q != '0);

  // Bounds computed one bit wider than the operands so they cannot wrap
  assign x_end = {1'b0, x0_q} + {1'b0, width_q};
  assign y_end = {1'b0, y0_q} + {1'b0, height_q};

  assign iss_load = (state_q == S_CHECK) || ((state_q == S_FILL) && wr_acc && iss_last);
  assign iss_adv  = ((state_q == S_FILL) && wr_acc) || ((state_q == S_VERIFY) && rd_acc);
  assign rsp_load = (state_q == S_CHECK);

  vga_raster_walker u_issue_walker (
    .clk_i(i_clk), .rst_ni(i_reset_n), .load_i(iss_load),
    .x0_i(x0_q), .y0_i(y0_q), .width_i(width_q), .height_i(height_q),
    .advance_i(iss_adv), .x_o(iss_x), .y_o(iss_y),
    .nxt_x_o(iss_nxt_x), .nxt_y_o(iss_nxt_y), .last_o(iss_last)
  );

  vga_raster_walker u_resp_walker (
    .clk_i(i_clk), .rst_ni(i_reset_n), .load_i(rsp_load),
    .x0_i(x0_q), .y0_i(y0_q), .width_i(width_q), .height_i(height_q),
    .advance_i(rsp_fire), .x_o(rsp_x), .y_o(rsp_y),
    .nxt_x_o(rsp_nxt_x), .nxt_y_o(rsp_nxt_y), .last_o(rsp_last)
  );

  logic unused_sink;
  assign unused_sink = ^{iss_x, iss_y, rsp_x, rsp_y, rsp_nxt_x, rsp_nxt_y, i_readdata[31:3]};

  // Outstanding-read count: accepted read and response in one cycle cancel
  always_comb begin
    pending_d = pending_q;
    if (rd_acc)   pending_d = pending_d + PW'(1);
    if (rsp_fire) pending_d = pending_d - PW'(1);
  end

  // Command FSM with registered bus and status outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      width_q      <= '0;
      height_q     <= '0;
      color_q      <= '0;
      verify_q     <= 1'b0;
      swap_q       <= 1'b0;
      issued_all_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      address_q    <= '0;
      writedata_q  <= '0;
      mismatch_q   <= '0;
      pending_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q      <= S_CHECK;
            busy_q       <= 1'b1;
            x0_q         <= i_x0;
            y0_q         <= i_y0;
            width_q      <= i_width;
            height_q     <= i_height;
            color_q      <= i_color;
            verify_q     <= i_verify;
            swap_q       <= i_swap;
            issued_all_q <= 1'b0;
            pending_q    <= '0;
            mismatch_q   <= '0;
          end
        end
        S_CHECK: begin
          if (width_q == '0 || height_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (x_end > 11'(H_PIXELS) || y_end > 10'(V_PIXELS)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            error_q <= 1'b1;
          end else begin
            state_q     <= S_FILL;
            write_q     <= 1'b1;
            address_q   <= pixel_addr(y0_q, x0_q);
            writedata_q <= {29'b0, color_q};
          end
        end
        S_FILL: begin
          if (wr_acc) begin
            if (!iss_last) begin
              address_q <= pixel_addr(iss_nxt_y, iss_nxt_x);
            end else if (verify_q) begin
              state_q     <= S_VERIFY;
              write_q     <= 1'b0;
              read_q      <= 1'b1;
              address_q   <= pixel_addr(y0_q, x0_q);
              writedata_q <= '0;
            end else if (swap_q) begin
              state_q     <= S_SWAP;
              address_q   <= SWAP_ADDR;
              writedata_q <= '0;
            end else begin
              state_q     <= S_DONE;
              write_q     <= 1'b0;
              address_q   <= '0;
              writedata_q <= '0;
              done_q      <= 1'b1;
            end
          end
        end
        S_VERIFY: begin
          pending_q <= pending_d;
          if (rsp_fire && (i_readdata[2:0] != color_q) && (mismatch_q != 16'hFFFF))
            mismatch_q <= mismatch_q + 16'd1;
          if (rd_acc) begin
            if (iss_last) begin
              read_q       <= 1'b0;
              issued_all_q <= 1'b1;
            end else begin
              address_q <= pixel_addr(iss_nxt_y, iss_nxt_x);
              read_q    <= (pending_d < PW'(MAX_PENDING));
            end
          end else if (!read_q && !issued_all_q) begin
            read_q <= (pending_d < PW'(MAX_PENDING));
          end
          // Responses are in order, so the last expected response drains the pipe
          if (rsp_fire && rsp_last) begin
            issued_all_q <= 1'b0;
            if (swap_q) begin
              state_q     <= S_SWAP;
              write_q     <= 1'b1;
              address_q   <= SWAP_ADDR;
              writedata_q <= '0;
            end else begin
              state_q   <= S_DONE;
              address_q <= '0;
              done_q    <= 1'b1;
            end
          end
        end
        S_SWAP: begin
          if (wr_acc) begin
            state_q   <= S_DONE;
            write_q   <= 1'b0;
            address_q <= '0;
            done_q    <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_error        = error_q;
  assign o_mismatch_cnt = mismatch_q;
  assign o_address      = address_q;
  assign o_write        = write_q;
  assign o_read         = read_q;
  assign o_writedata    = writedata_q;

endmodule
`default_nettype wire
